con_ff_unit: RTL and testbench
==============================

Name: con_ff_unit

Overview:
- Parametrised branch-condition unit for the datapath's conditional-branch step.
- Captures a condition code from the instruction register and an operand from the bus.
- Compares the operand against zero or against a previously latched reference register, signed or unsigned.
- Holds the registered taken/not-taken result until the control unit acknowledges it, and keeps a saturating count of taken branches.

Parameters:
- DATA_WIDTH, 32: width of bus and operand registers.
- COND_LSB, 19: bit position of the 3-bit condition field within instruction.
- CNT_WIDTH, 16: width of taken_count.

Ports:
- clk  input  1  system clock, rising edge.
- clear  input  1  reset, synchronous, active-high.
- instruction  input  32  current instruction register contents.
- bus  input  DATA_WIDTH  datapath bus.
- CONin  input  1  start evaluation; captures condition and operand.
- REFin  input  1  latch bus into reference register.
- ref_mode  input  1  0 = compare against zero, 1 = compare against reference register; sampled with CONin.
- unsigned_mode  input  1  0 = two's-complement compare, 1 = unsigned; sampled with CONin.
- branch_ack  input  1  control unit has consumed the result.
- out  output  1  branch taken.
- out_valid  output  1  out holds a fresh result.
- busy  output  1  state != IDLE (combinational from state).
- taken_count  output  CNT_WIDTH  saturating count of taken results.

Behaviour:
- Reset: clear sampled high at a rising edge forces the following, regardless of state or other inputs (reset mid-operation discards the pending evaluation):
  - state = IDLE;
  - out = 0, out_valid = 0, taken_count = 0;
  - operand, reference and condition registers = 0.
- Condition encoding (instruction[COND_LSB+2:COND_LSB]):
  - 000 EQ, 001 NE, 010 GE, 011 LT, 100 GT, 101 LE, 110 ALWAYS, 111 NEVER.
  - Codes 000–011 are the legacy branch conditions.
- Comparison: operand A (captured) versus B, where B = 0 if ref_mode = 0, otherwise B = reference register.
  - Signed mode: full DATA_WIDTH two's-complement compare.
  - Unsigned mode: natural-binary compare; against zero, LT is always 0 and GE always 1.
  - No overflow path: direct relational compare, not subtraction.
- FSM states: IDLE, EVAL, HOLD.
  - IDLE: on CONin = 1, capture condition field, bus into operand, ref_mode and unsigned_mode; go to EVAL.
  - EVAL (exactly one cycle): out <= result, out_valid <= 1; if result = 1 and taken_count != all-ones, increment taken_count; go to HOLD.
  - HOLD: out and out_valid stable until branch_ack = 1; then out_valid <= 0, out <= 0, go to IDLE.
- Latency: CONin sampled at edge n; out/out_valid valid after edge n+1, i.e. out_valid visible during the cycle after EVAL.
- Single-outstanding rule:
  - CONin is ignored while busy = 1; no queueing.
  - branch_ack is ignored unless out_valid = 1.
- Reference register:
  - REFin is honoured only in IDLE; ignored in EVAL/HOLD so the compare value is stable.
  - CONin and REFin in the same IDLE cycle: both capture the same bus value (a ref-mode compare then sees A == B).
- Simultaneous events:
  - branch_ack and CONin in the same HOLD cycle: the ack is taken and CONin is ignored; the next CONin is accepted at the earliest in the following IDLE cycle.
- taken_count saturates at 2^CNT_WIDTH − 1 and never wraps; only clear resets it.

Test Plan:
- Reset then zero-compare EQ: clear pulse, bus = 0, cond = 000, ref_mode = 0, CONin for one cycle.
  - Required: out = 1, out_valid = 1 two edges later; taken_count = 1.
  - Hold branch_ack low 3 cycles: out stays 1. Assert branch_ack: next cycle out = 0, out_valid = 0, busy = 0.
- Signed vs unsigned, bus = 0xFFFFFFFF, cond = 011 (LT), zero compare:
  - unsigned_mode = 0: out = 1.
  - unsigned_mode = 1: out = 0.
- Reference compare:
  - REFin with bus = 100; then CONin with bus = 50, ref_mode = 1, cond = 100 (GT): out = 0.
  - Repeat with cond = 101 (LE): out = 1.
  - REFin with bus = 7 during HOLD: reference register stays 100.
- Busy lockout and ack collision:
  - CONin during EVAL with a different condition: result unchanged.
  - branch_ack + CONin in the same HOLD cycle: returns to IDLE, no new evaluation starts.
- Saturation with CNT_WIDTH = 2: five ALWAYS (110) evaluations.
  - Required: taken_count sequence 1, 2, 3, 3, 3.
  - NEVER (111) evaluation: out = 0, count unchanged.
- Reset mid-operation: clear asserted in EVAL.
  - Required: next cycle state IDLE, out = 0, out_valid = 0, taken_count = 0, reference register = 0.

Source files
------------

// File: rtl/con_ff_unit.sv
// ---------------------------------------------------------------------------
// con_ff_unit
//
// Branch-condition unit for the conditional-branch step of the datapath.
// A CONin pulse captures a 3-bit condition code from the instruction
// register together with an operand from the bus. One cycle later the
// operand is compared against zero or against a previously latched
// reference value, either signed or unsigned. The taken/not-taken result is
// held until the control unit acknowledges it. A saturating counter records
// how many evaluations were taken.
//
// Handshake: CONin starts one evaluation and is accepted only when busy is 0.
// out_valid rises with the result and stays high, with out stable, until a
// cycle in which branch_ack is 1. That cycle consumes the result. branch_ack
// has no effect while out_valid is 0. Only one evaluation can be outstanding.
//
// Ports:
//   clk           in   rising-edge clock
//   clear         in   synchronous active-high reset
//   instruction   in   instruction register, condition at [COND_LSB+2:COND_LSB]
//   bus           in   datapath bus (operand / reference source)
//   CONin         in   start evaluation (captures condition, operand, modes)
//   REFin         in   latch bus into the reference register (IDLE only)
//   ref_mode      in   0: compare with zero, 1: compare with reference register
//   unsigned_mode in   0: two's-complement compare, 1: unsigned compare
//   branch_ack    in   control unit has consumed the result
//   out           out  branch taken
//   out_valid     out  out holds a fresh result
//   busy          out  FSM is not in IDLE
//   taken_count   out  saturating count of taken results
//   dbg_state_o   out  FSM state (0 IDLE, 1 EVAL, 2 HOLD)
//   dbg_ref_o     out  current reference register contents
// ---------------------------------------------------------------------------
module con_ff_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int COND_LSB   = 19,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic [31:0]           instruction,
    input  logic [DATA_WIDTH-1:0] bus,
    input  logic                  CONin,
    input  logic                  REFin,
    input  logic                  ref_mode,
    input  logic                  unsigned_mode,
    input  logic                  branch_ack,
    output logic                  out,
    output logic                  out_valid,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  taken_count,
    output logic [1:0]            dbg_state_o,
    output logic [DATA_WIDTH-1:0] dbg_ref_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Condition codes. 000-011 match the legacy branch conditions.
    localparam logic [2:0] C_EQ = 3'b000;
    localparam logic [2:0] C_NE = 3'b001;
    localparam logic [2:0] C_GE = 3'b010;
    localparam logic [2:0] C_LT = 3'b011;
    localparam logic [2:0] C_GT = 3'b100;
    localparam logic [2:0] C_LE = 3'b101;
    localparam logic [2:0] C_AL = 3'b110;
    localparam logic [2:0] C_NV = 3'b111;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e                 state_q, state_d;
    logic [2:0]             cond_q, cond_d;
    logic [DATA_WIDTH-1:0]  opa_q, opa_d;
    logic [DATA_WIDTH-1:0]  ref_q, ref_d;
    logic                   refmode_q, refmode_d;
    logic                   unsmode_q, unsmode_d;
    logic                   out_q, out_d;
    logic                   out_valid_q, out_valid_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    // Only the condition field of the instruction is used. The remaining
    // bits are folded here so their non-use is explicit.
    logic unused_instr;
    assign unused_instr = ^(instruction & ~(32'h7 << COND_LSB));

    logic [2:0] cond_field;
    assign cond_field = instruction[COND_LSB +: 3];

    // ------------------------------------------------------------------
    // Comparator: direct relational compare of the captured operand with
    // either zero or the reference register. No subtraction, so there is
    // no overflow case to handle. In unsigned mode against zero, lt is
    // always 0, so GE resolves to 1 and LT to 0.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] cmp_b;
    logic                  cmp_eq;
    logic                  cmp_lt;
    logic                  cmp_gt;
    logic                  result;

    assign cmp_b  = refmode_q ? ref_q : '0;
    assign cmp_eq = (opa_q == cmp_b);

    always_comb begin
        if (unsmode_q) begin
            cmp_lt = (opa_q < cmp_b);
            cmp_gt = (opa_q > cmp_b);
        end else begin
            cmp_lt = ($signed(opa_q) < $signed(cmp_b));
            cmp_gt = ($signed(opa_q) > $signed(cmp_b));
        end
    end

    always_comb begin
        result = 1'b0;
        unique case (cond_q)
            C_EQ:    result = cmp_eq;
            C_NE:    result = !cmp_eq;
            C_GE:    result = !cmp_lt;
            C_LT:    result = cmp_lt;
            C_GT:    result = cmp_gt;
            C_LE:    result = !cmp_gt;
            C_AL:    result = 1'b1;
            C_NV:    result = 1'b0;
            default: result = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cond_d      = cond_q;
        opa_d       = opa_q;
        ref_d       = ref_q;
        refmode_d   = refmode_q;
        unsmode_d   = unsmode_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                // The reference register accepts new values only here, so
                // the compare value stays stable during an evaluation. If
                // REFin and CONin are both high, both registers take the
                // same bus value.
                if (REFin) begin
                    ref_d = bus;
                end
                if (CONin) begin
                    cond_d    = cond_field;
                    opa_d     = bus;
                    refmode_d = ref_mode;
                    unsmode_d = unsigned_mode;
                    state_d   = EVAL;
                end
            end

            EVAL: begin
                out_d       = result;
                out_valid_d = 1'b1;
                if (result && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
                state_d = HOLD;
            end

            HOLD: begin
                // CONin in this cycle is dropped even when it coincides
                // with the ack. A new evaluation needs a fresh CONin in IDLE.
                if (branch_ack && out_valid_q) begin
                    out_d       = 1'b0;
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q     <= IDLE;
            cond_q      <= 3'b000;
            opa_q       <= '0;
            ref_q       <= '0;
            refmode_q   <= 1'b0;
            unsmode_q   <= 1'b0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cond_q      <= cond_d;
            opa_q       <= opa_d;
            ref_q       <= ref_d;
            refmode_q   <= refmode_d;
            unsmode_q   <= unsmode_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out         = out_q;
    assign out_valid   = out_valid_q;
    assign busy        = (state_q != IDLE);
    assign taken_count = cnt_q;
    assign dbg_state_o = state_q;
    assign dbg_ref_o   = ref_q;

endmodule

// File: tb/tb_con_ff_unit.sv
module tb_con_ff_unit;

    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          clear = 1'b0;
    logic [31:0]   instruction = '0;
    logic [DW-1:0] bus = '0;
    logic          CONin = 1'b0;
    logic          REFin = 1'b0;
    logic          ref_mode = 1'b0;
    logic          unsigned_mode = 1'b0;
    logic          branch_ack = 1'b0;

    logic          out, out_valid, busy;
    logic [15:0]   taken_count;
    logic [1:0]    dbg_state;
    logic [DW-1:0] dbg_ref;

    // Second instance with a 2-bit counter, fed the same stimulus, to
    // exercise saturation.
    logic          s_out, s_out_valid, s_busy;
    logic [1:0]    s_taken_count;
    logic [1:0]    s_dbg_state;
    logic [DW-1:0] s_dbg_ref;

    con_ff_unit #(.DATA_WIDTH(DW), .COND_LSB(19), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .clear(clear), .instruction(instruction), .bus(bus),
        .CONin(CONin), .REFin(REFin), .ref_mode(ref_mode),
        .unsigned_mode(unsigned_mode), .branch_ack(branch_ack),
        .out(out), .out_valid(out_valid), .busy(busy),
        .taken_count(taken_count), .dbg_state_o(dbg_state), .dbg_ref_o(dbg_ref)
    );

    con_ff_unit #(.DATA_WIDTH(DW), .COND_LSB(19), .CNT_WIDTH(2)) u_sat (
        .clk(clk), .clear(clear), .instruction(instruction), .bus(bus),
        .CONin(CONin), .REFin(REFin), .ref_mode(ref_mode),
        .unsigned_mode(unsigned_mode), .branch_ack(branch_ack),
        .out(s_out), .out_valid(s_out_valid), .busy(s_busy),
        .taken_count(s_taken_count), .dbg_state_o(s_dbg_state), .dbg_ref_o(s_dbg_ref)
    );

    // ---------------- reference model state ----------------
    logic [DW-1:0] m_ref;
    int unsigned   m_cnt;    // 16-bit instance count
    int unsigned   m_cnt2;   // 2-bit instance count

    int vectors = 0;
    int miscompares = 0;

    // Taken decision computed from the condition table using wide integer
    // arithmetic, signed or unsigned as selected.
    function automatic bit model_taken(input logic [2:0] c, input logic [DW-1:0] a,
                                       input logic [DW-1:0] b, input bit uns);
        longint sa, sb;
        if (uns) begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end else begin
            sa = $signed(a);
            sb = $signed(b);
        end
        case (c)
            3'd0: return sa == sb;
            3'd1: return sa != sb;
            3'd2: return sa >= sb;
            3'd3: return sa <  sb;
            3'd4: return sa >  sb;
            3'd5: return sa <= sb;
            3'd6: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // ---------------- scoreboard check ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_ref  = '0;
        m_cnt  = 0;
        m_cnt2 = 0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        CONin = 1'b0;
        REFin = 1'b0;
        branch_ack = 1'b0;
        step();
        clear = 1'b0;
        model_reset();
        chk("rst_busy", busy, 0);
        chk("rst_out", out, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_cnt", taken_count, 0);
        chk("rst_ref", dbg_ref, 0);
        chk("rst_cnt2", s_taken_count, 0);
    endtask

    task automatic load_ref(input logic [DW-1:0] v);
        bus = v;
        REFin = 1'b1;
        step();
        REFin = 1'b0;
        m_ref = v;
        chk("ref_load", dbg_ref, m_ref);
        chk("ref_idle", busy, 0);
    endtask

    // One full evaluation. poke drives a conflicting CONin in EVAL and HOLD,
    // refpoke drives REFin (bus = 7) during HOLD, collide raises CONin with
    // the ack, with_ref raises REFin together with CONin.
    task automatic run_eval(input logic [2:0] c, input logic [DW-1:0] a, input bit rm,
                            input bit uns, input int hold, input bit poke,
                            input bit refpoke, input bit collide, input bit with_ref);
        bit exp_out;
        logic [DW-1:0] b;
        if (with_ref) m_ref = a;
        b = rm ? m_ref : '0;
        exp_out = model_taken(c, a, b, uns);

        instruction = $urandom;
        instruction[21:19] = c;
        bus = a;
        ref_mode = rm;
        unsigned_mode = uns;
        CONin = 1'b1;
        REFin = with_ref;
        step();
        CONin = 1'b0;
        REFin = 1'b0;
        chk("eval_busy", busy, 1);
        chk("eval_valid", out_valid, 0);

        if (poke) begin
            instruction[21:19] = ~c;
            bus = ~a;
            ref_mode = ~rm;
            unsigned_mode = ~uns;
            CONin = 1'b1;
        end
        step();
        if (exp_out) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        chk("res_out", out, exp_out);
        chk("res_valid", out_valid, 1);
        chk("res_cnt", taken_count, m_cnt);
        chk("res_cnt2", s_taken_count, m_cnt2);

        for (int i = 0; i < hold; i++) begin
            if (refpoke) begin
                bus = 32'd7;
                REFin = 1'b1;
            end
            step();
            chk("hold_out", out, exp_out);
            chk("hold_valid", out_valid, 1);
        end
        REFin = 1'b0;
        chk("hold_ref", dbg_ref, m_ref);

        branch_ack = 1'b1;
        CONin = collide;
        step();
        branch_ack = 1'b0;
        CONin = 1'b0;
        chk("ack_out", out, 0);
        chk("ack_valid", out_valid, 0);
        chk("ack_busy", busy, 0);
        if (collide) begin
            step();
            chk("coll_busy", busy, 0);
            chk("coll_valid", out_valid, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [DW-1:0] ra;
        model_reset();
        #1;
        do_clear();

        // zero compare EQ, bus = 0, held three cycles before the ack
        run_eval(3'b000, 32'd0, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("first_cnt", taken_count, 1);

        // 0xFFFFFFFF LT zero: signed taken, unsigned not
        run_eval(3'b011, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_eval(3'b011, 32'hFFFF_FFFF, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        // unsigned GE against zero is always taken
        run_eval(3'b010, 32'h8000_0000, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // reference compare: 50 GT 100 no, 50 LE 100 yes, REFin in HOLD ignored
        load_ref(32'd100);
        run_eval(3'b100, 32'd50, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_eval(3'b101, 32'd50, 1'b1, 1'b0, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        run_eval(3'b000, 32'd100, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // CONin during EVAL/HOLD ignored; ack and CONin collide in HOLD
        run_eval(3'b001, 32'd100, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0, 1'b0);
        run_eval(3'b000, 32'd100, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0);

        // CONin and REFin together: A == B
        run_eval(3'b000, 32'h1234_5678, 1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);

        // saturation of the 2-bit counter: 1,2,3,3,3, then NEVER
        do_clear();
        for (int i = 0; i < 5; i++) begin
            run_eval(3'b110, $urandom, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("sat_seq", s_taken_count, (i < 3) ? i + 1 : 3);
        end
        run_eval(3'b111, 32'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("never_cnt2", s_taken_count, 3);

        // clear during EVAL discards the evaluation
        load_ref(32'd55);
        instruction[21:19] = 3'b110;
        bus = 32'd1;
        CONin = 1'b1;
        step();
        CONin = 1'b0;
        chk("mid_busy", busy, 1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_reset();
        chk("mid_state", dbg_state, 0);
        chk("mid_out", out, 0);
        chk("mid_valid", out_valid, 0);
        chk("mid_cnt", taken_count, 0);
        chk("mid_ref", dbg_ref, 0);
        step();
        chk("mid_stay_idle", busy, 0);

        // randomized evaluations
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0) load_ref($urandom);
            case ($urandom_range(0, 3))
                0: ra = m_ref;
                1: ra = m_ref + 32'd1;
                2: ra = m_ref - 32'd1;
                default: ra = $urandom;
            endcase
            run_eval(3'($urandom_range(0, 7)), ra, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
